pcie_rx_bridge_mc: RTL
======================

PCIE_RX_BRIDGE_MC -- requirements
Module: pcie_rx_bridge_mc

Interface
REQ-001 SHALL provide parameter NUM_CH, default 2, meaning TLP channels per beat (1..4).
REQ-002 SHALL provide parameter HDR_W, default 128, meaning header bits per channel.
REQ-003 SHALL provide parameter DATA_W, default 256, meaning payload bits per channel.
REQ-004 SHALL provide parameter READY_LATENCY, default 3, meaning Avalon-ST ready latency in cycles (0..8).
REQ-005 SHALL provide parameter FIFO_DEPTH, default 16, meaning beat FIFO entries; power of 2, >= READY_LATENCY+2.
REQ-006 SHALL provide avl_clk  in  1  sole clock; one clock; all logic on its rising edge.
REQ-007 SHALL provide avl_rst  in  1  reset, synchronous and active-high.
REQ-008 SHALL provide avl_rx_valid  in  NUM_CH  per-channel valid.
REQ-009 SHALL provide avl_rx_sop / avl_rx_eop  in  NUM_CH each  per-channel start/end of TLP.
REQ-010 SHALL provide avl_rx_hdr  in  NUM_CH*HDR_W  channel i at [i*HDR_W +: HDR_W].
REQ-011 SHALL provide avl_rx_data  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W].
REQ-012 SHALL provide avl_rx_ready  out  1  registered ready to Avalon source.
REQ-013 SHALL provide axis_rx_tvalid  out  1  beat valid; axis_rx_tready  in  1  sink ready.
REQ-014 SHALL provide axis_rx_slot_valid, axis_rx_sop, axis_rx_eop  out  NUM_CH each; axis_rx_hdr  out  NUM_CH*HDR_W; axis_rx_payload  out  NUM_CH*DATA_W; same channel packing as inputs.
REQ-015 SHALL provide proto_err  out  1  one-cycle pulse on framing violation; err_cnt  out  16  saturating violation count; overflow  out  1  sticky FIFO overflow flag.

Function
REQ-016 SHALL write a beat (all channel fields, unmodified) into the FIFO in any cycle where |avl_rx_valid is 1; beats with all valid bits 0 SHALL NOT be written.
REQ-017 SHALL accept writes regardless of avl_rx_ready (source obeys ready latency); ready is flow control only.
REQ-018 SHALL register avl_rx_ready <= (count_next <= FIFO_DEPTH-READY_LATENCY-1), count_next = occupancy after this cycle's push/pop.
REQ-019 SHALL drive axis_rx_tvalid = FIFO non-empty, outputs from FIFO head; pop when axis_rx_tvalid && axis_rx_tready.
REQ-020 SHALL present a beat written in cycle t on the AXI outputs in cycle t+1 at earliest (latency 1 when empty).
REQ-021 SHALL hold AXI outputs stable while axis_rx_tvalid=1 and axis_rx_tready=0.
REQ-022 SHALL, when full with simultaneous pop, accept the push (occupancy unchanged); when full without pop, drop the beat, set overflow, leave FIFO contents unchanged.
REQ-023 SHALL wrap read/write pointers modulo FIFO_DEPTH; occupancy kept as log2(FIFO_DEPTH)+1 bits.
REQ-024 SHALL track framing with one in_pkt bit, evaluated across valid channels ch0..NUM_CH-1 in order, carried to next beat's ch0.
REQ-025 SHALL flag a violation on a valid channel when: sop=1 while in_pkt=1, or sop=0 while in_pkt=0; in_pkt after channel = eop ? 0 : 1 (sop&eop same channel legal single-channel TLP).
REQ-026 SHALL pulse proto_err for one cycle (the cycle after the beat) if any channel of that beat violated; err_cnt increments by 1 per violating beat, saturating at 16'hFFFF.
REQ-027 SHALL forward violating beats unchanged (checking is non-blocking).
REQ-028 SHALL ignore fields of channels whose valid bit is 0 for framing.

Reset
REQ-029 SHALL, while avl_rst=1, drive avl_rx_ready=0, axis_rx_tvalid=0, proto_err=0, err_cnt=0, overflow=0, in_pkt=0, pointers and occupancy 0.
REQ-030 SHALL ignore input beats in reset cycles; reset mid-packet discards FIFO contents and framing state.
REQ-031 SHALL assert avl_rx_ready in the first cycle after avl_rst deasserts.
REQ-032 SHALL NOT require FIFO data storage to be reset.

Verification
REQ-033 Single beat ch0 sop=1 eop=1 into empty FIFO, tready=1 -> axis_rx_tvalid=1 next cycle with identical hdr/payload, slot_valid=2'b01, proto_err=0.
REQ-034 tready=0, continuous valid beats honoring RL=3, depth 16 -> avl_rx_ready falls when occupancy reaches 13; no overflow; all 16 beats delivered in order once tready=1.
REQ-035 Source ignores ready, pushes 17 beats with tready=0 -> overflow=1, 17th beat dropped, first 16 intact.
REQ-036 TLP ch1 sop, next beat ch0 eop -> no error; then beat ch0 sop=0 eop=1 with no open packet -> proto_err pulse, err_cnt=1, beat still forwarded.
REQ-037 Full FIFO with push and pop same cycle -> occupancy stays 16, no overflow, pushed beat delivered last.
REQ-038 avl_rst asserted mid-packet with 5 beats queued -> tvalid=0, err_cnt=0, ready=1 one cycle after release, next sop accepted without error.

Source files
------------

// File: rtl/pcie_rx_bridge_mc.sv
// Multi-channel PCIe RX bridge: Avalon-ST (ready latency) beats into an AXI-Stream
// beat FIFO, with non-blocking TLP framing checks and overflow reporting.
module pcie_rx_bridge_mc #(
    parameter int NUM_CH        = 2,
    parameter int HDR_W         = 128,
    parameter int DATA_W        = 256,
    parameter int READY_LATENCY = 3,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                     avl_clk,
    input  logic                     avl_rst,
    input  logic [NUM_CH-1:0]        avl_rx_valid,
    input  logic [NUM_CH-1:0]        avl_rx_sop,
    input  logic [NUM_CH-1:0]        avl_rx_eop,
    input  logic [NUM_CH*HDR_W-1:0]  avl_rx_hdr,
    input  logic [NUM_CH*DATA_W-1:0] avl_rx_data,
    output logic                     avl_rx_ready,
    output logic                     axis_rx_tvalid,
    input  logic                     axis_rx_tready,
    output logic [NUM_CH-1:0]        axis_rx_slot_valid,
    output logic [NUM_CH-1:0]        axis_rx_sop,
    output logic [NUM_CH-1:0]        axis_rx_eop,
    output logic [NUM_CH*HDR_W-1:0]  axis_rx_hdr,
    output logic [NUM_CH*DATA_W-1:0] axis_rx_payload,
    output logic                     proto_err,
    output logic [15:0]              err_cnt,
    output logic                     overflow
);

    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FLAG_W = 3 * NUM_CH;
    localparam int HW     = NUM_CH * HDR_W;
    localparam int DW     = NUM_CH * DATA_W;
    localparam int BEAT_W = FLAG_W + HW + DW;

    localparam logic [AW:0]   CNT_ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE_C   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   READY_THR_C = (AW+1)'(FIFO_DEPTH - READY_LATENCY - 1);
    localparam logic [AW-1:0] PTR_ZERO_C  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE_C   = AW'(1);

    logic [BEAT_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              in_pkt_r;
    logic              ready_r;
    logic              tvalid_r;
    logic              proto_err_r;
    logic [15:0]       err_cnt_r;
    logic              overflow_r;

    logic              push_req_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic [AW:0]       count_next_s;
    logic              viol_s;
    logic              pkt_next_s;
    logic [BEAT_W-1:0] wr_beat_s;
    logic [BEAT_W-1:0] head_s;

    assign push_req_s = |avl_rx_valid;
    assign full_s     = (count_r == CNT_FULL_C);
    assign pop_s      = tvalid_r & axis_rx_tready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign drop_s     = push_req_s & full_s & ~pop_s;
    assign wr_beat_s  = {avl_rx_valid, avl_rx_sop, avl_rx_eop, avl_rx_hdr, avl_rx_data};
    assign head_s     = mem_r[rd_ptr_r];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE_C;
            2'b01:   count_next_s = count_r - CNT_ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Framing walk over valid channels in order, carrying in_pkt across channels.
    always_comb begin
        viol_s     = 1'b0;
        pkt_next_s = in_pkt_r;
        for (int i = 0; i < NUM_CH; i++) begin
            if (avl_rx_valid[i]) begin
                viol_s     = viol_s | (avl_rx_sop[i] == pkt_next_s);
                pkt_next_s = ~avl_rx_eop[i];
            end else begin
                pkt_next_s = pkt_next_s;
            end
        end
    end

    // Beat storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge avl_clk) begin
        if (push_s && !avl_rst) begin
            mem_r[wr_ptr_r] <= wr_beat_s;
        end
    end

    // Pointers, occupancy, flow control, framing state and error reporting.
    always_ff @(posedge avl_clk) begin
        if (avl_rst) begin
            wr_ptr_r    <= PTR_ZERO_C;
            rd_ptr_r    <= PTR_ZERO_C;
            count_r     <= CNT_ZERO_C;
            in_pkt_r    <= 1'b0;
            ready_r     <= 1'b0;
            tvalid_r    <= 1'b0;
            proto_err_r <= 1'b0;
            err_cnt_r   <= 16'h0000;
            overflow_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r     <= count_next_s;
            tvalid_r    <= (count_next_s != CNT_ZERO_C);
            ready_r     <= (count_next_s <= READY_THR_C);
            in_pkt_r    <= pkt_next_s;
            proto_err_r <= viol_s;
            if (viol_s && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'h0001;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign avl_rx_ready       = ready_r;
    assign axis_rx_tvalid     = tvalid_r;
    assign axis_rx_slot_valid = head_s[BEAT_W-1 -: NUM_CH];
    assign axis_rx_sop        = head_s[BEAT_W-NUM_CH-1 -: NUM_CH];
    assign axis_rx_eop        = head_s[BEAT_W-2*NUM_CH-1 -: NUM_CH];
    assign axis_rx_hdr        = head_s[DW +: HW];
    assign axis_rx_payload    = head_s[0 +: DW];
    assign proto_err          = proto_err_r;
    assign err_cnt            = err_cnt_r;
    assign overflow           = overflow_r;

endmodule
